// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the MU0 control sequencer.
//   OP_*      opcode encodings 0..10 (LDA STA ADD SUB JMP JMI JEQ STP LDI LSL LSR)
//   state_t   sequencer states FETCH / EXEC1 / EXEC2 / HALT
//   alu_op_t  ALU operation select driven on aluOp
package mu0_pkg;

   localparam logic [3:0] OP_LDA = 4'd0;
   localparam logic [3:0] OP_STA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_JMP = 4'd4;
   localparam logic [3:0] OP_JMI = 4'd5;
   localparam logic [3:0] OP_JEQ = 4'd6;
   localparam logic [3:0] OP_STP = 4'd7;
   localparam logic [3:0] OP_LDI = 4'd8;
   localparam logic [3:0] OP_LSL = 4'd9;
   localparam logic [3:0] OP_LSR = 4'd10;

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC1,
      S_EXEC2,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_PASS_MEM = 3'd0,
      ALU_ADD      = 3'd1,
      ALU_SUB      = 3'd2,
      ALU_PASS_IMM = 3'd3,
      ALU_LSL      = 3'd4,
      ALU_LSR      = 3'd5
   } alu_op_t;

endpackage

// File: rtl/mu0_sequencer_if.sv
// mu0_sequencer_if: datapath <-> sequencer signal bundle.
//   master : sequencer side  (inputs opcode/eq/mi/memReady/resume,
//            outputs enables, addrSel, aluOp, state flags, illegal, retired)
//   slave  : datapath / memory side (mirror directions)
interface mu0_sequencer_if
   import mu0_pkg::*;
#(
   parameter int unsigned OPW  = 4,
   parameter int unsigned CNTW = 16
);
   logic [OPW-1:0]  opcode;
   logic            eq;
   logic            mi;
   logic            memReady;
   logic            resume;
   logic            irLoad;
   logic            ramWrEn;
   logic            accLoad;
   logic            pcEnable;
   logic            pcSLoad;
   logic            addrSel;
   alu_op_t         aluOp;
   logic            fetch;
   logic            exec1;
   logic            exec2;
   logic            halted;
   logic            illegal;
   logic [CNTW-1:0] retired;

   modport master (
      input  opcode, eq, mi, memReady, resume,
      output irLoad, ramWrEn, accLoad, pcEnable, pcSLoad, addrSel, aluOp,
             fetch, exec1, exec2, halted, illegal, retired
   );

   modport slave (
      output opcode, eq, mi, memReady, resume,
      input  irLoad, ramWrEn, accLoad, pcEnable, pcSLoad, addrSel, aluOp,
             fetch, exec1, exec2, halted, illegal, retired
   );
endinterface

// File: rtl/mu0_opdecode.sv
// mu0_opdecode: combinational opcode classifier.
//   opcode      in  : IR opcode field (OPW bits)
//   is_extra    out : needs a second (EXEC2) memory-read cycle (LDA/ADD/SUB)
//   is_write    out : RAM write in EXEC1 (STA)
//   is_jump     out : any jump; jmp_always / jmp_on_mi / jmp_on_eq give the condition
//   is_imm      out : single-cycle accumulator op (LDI/LSL/LSR)
//   is_stop     out : STP
//   is_illegal  out : unknown opcode
//   alu_op      out : ALU operation for the accumulator load
// Build option: MU0_EXT_OPS_EN enables LDI/LSL/LSR; otherwise they decode as illegal.
module mu0_opdecode
   import mu0_pkg::*;
#(
   parameter int unsigned OPW = 4
) (
   input  logic [OPW-1:0] opcode,
   output logic           is_extra,
   output logic           is_write,
   output logic           is_jump,
   output logic           jmp_always,
   output logic           jmp_on_mi,
   output logic           jmp_on_eq,
   output logic           is_imm,
   output logic           is_stop,
   output logic           is_illegal,
   output alu_op_t        alu_op
);

   always_comb begin
      is_extra   = 1'b0;
      is_write   = 1'b0;
      jmp_always = 1'b0;
      jmp_on_mi  = 1'b0;
      jmp_on_eq  = 1'b0;
      is_imm     = 1'b0;
      is_stop    = 1'b0;
      is_illegal = 1'b0;
      alu_op     = ALU_PASS_MEM;
      // Anything above the last defined opcode is rejected on the full width,
      // so the low-nibble case below only ever sees 0..10.
      if (opcode > OPW'(OP_LSR)) begin
         is_illegal = 1'b1;
      end else begin
         case (opcode[3:0])
            OP_LDA: is_extra = 1'b1;
            OP_STA: is_write = 1'b1;
            OP_ADD: begin is_extra = 1'b1; alu_op = ALU_ADD; end
            OP_SUB: begin is_extra = 1'b1; alu_op = ALU_SUB; end
            OP_JMP: jmp_always = 1'b1;
            OP_JMI: jmp_on_mi  = 1'b1;
            OP_JEQ: jmp_on_eq  = 1'b1;
            OP_STP: is_stop    = 1'b1;
`ifdef MU0_EXT_OPS_EN
            OP_LDI: begin is_imm = 1'b1; alu_op = ALU_PASS_IMM; end
            OP_LSL: begin is_imm = 1'b1; alu_op = ALU_LSL; end
            OP_LSR: begin is_imm = 1'b1; alu_op = ALU_LSR; end
`else
            OP_LDI, OP_LSL, OP_LSR: is_illegal = 1'b1;
`endif
            default: is_illegal = 1'b1;
         endcase
      end
   end

   assign is_jump = jmp_always | jmp_on_mi | jmp_on_eq;

endmodule

// File: rtl/mu0_sequencer.sv
// mu0_sequencer: MU0 control sequencer (FETCH / EXEC1 / EXEC2 / HALT).
//   clk    in : rising-edge clock
//   reset  in : synchronous active-high reset
//   bus       : mu0_sequencer_if.master -- opcode/eq/mi/memReady/resume in;
//               irLoad, ramWrEn, accLoad, pcEnable, pcSLoad, addrSel, aluOp,
//               fetch/exec1/exec2/halted, illegal, retired out
// Parameters: OPW opcode width (>= 4), CNTW retired-counter width.
// Build option: MU0_EXT_OPS_EN enables LDI/LSL/LSR (see mu0_opdecode).
module mu0_sequencer
   import mu0_pkg::*;
#(
   parameter int unsigned OPW  = 4,
   parameter int unsigned CNTW = 16
) (
   input  logic           clk,
   input  logic           reset,
   mu0_sequencer_if.master bus
);

   state_t          state, state_nx;
   logic            retire, set_illegal;
   logic [CNTW-1:0] retired_q;
   logic            illegal_q;
   logic            fetch_q, exec1_q, exec2_q, halted_q;

   logic    is_extra, is_write, is_jump, jmp_always, jmp_on_mi, jmp_on_eq;
   logic    is_imm, is_stop, is_illegal;
   alu_op_t dec_alu;

   mu0_opdecode #(.OPW(OPW)) u_dec (
      .opcode     (bus.opcode),
      .is_extra   (is_extra),
      .is_write   (is_write),
      .is_jump    (is_jump),
      .jmp_always (jmp_always),
      .jmp_on_mi  (jmp_on_mi),
      .jmp_on_eq  (jmp_on_eq),
      .is_imm     (is_imm),
      .is_stop    (is_stop),
      .is_illegal (is_illegal),
      .alu_op     (dec_alu)
   );

   always_comb begin
      state_nx    = state;
      retire      = 1'b0;
      set_illegal = 1'b0;
      case (state)
         S_FETCH: if (bus.memReady) state_nx = S_EXEC1;
         S_EXEC1: begin
            if (is_illegal) begin
               set_illegal = 1'b1;
               state_nx    = S_HALT;
            end else if (is_stop) begin
               retire   = 1'b1;
               state_nx = S_HALT;
            end else if (is_extra) begin
               if (bus.memReady) state_nx = S_EXEC2;
            end else if (is_write) begin
               if (bus.memReady) begin
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end
            end else begin
               // jumps and immediate ops complete unconditionally
               retire   = 1'b1;
               state_nx = S_FETCH;
            end
         end
         S_EXEC2: if (bus.memReady) begin
            retire   = 1'b1;
            state_nx = S_FETCH;
         end
         S_HALT:  if (bus.resume) state_nx = S_FETCH;
         default: state_nx = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         fetch_q   <= 1'b1;
         exec1_q   <= 1'b0;
         exec2_q   <= 1'b0;
         halted_q  <= 1'b0;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nx;
         fetch_q   <= (state_nx == S_FETCH);
         exec1_q   <= (state_nx == S_EXEC1);
         exec2_q   <= (state_nx == S_EXEC2);
         halted_q  <= (state_nx == S_HALT);
         if (retire && (retired_q != '1)) retired_q <= retired_q + CNTW'(1);
         if (set_illegal) illegal_q <= 1'b1;
      end
   end

   // Enables follow memReady/eq/mi in the same cycle, so they stay combinational
   // on the registered state; reset forces the idle pattern.
   always_comb begin
      bus.irLoad   = 1'b0;
      bus.ramWrEn  = 1'b0;
      bus.accLoad  = 1'b0;
      bus.pcEnable = 1'b0;
      bus.pcSLoad  = 1'b0;
      bus.addrSel  = 1'b1;
      bus.aluOp    = ALU_PASS_MEM;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               bus.irLoad   = bus.memReady;
               bus.pcEnable = bus.memReady;
            end
            S_EXEC1: begin
               if (is_extra) bus.addrSel = 1'b0;
               if (is_write) begin
                  bus.addrSel = 1'b0;
                  bus.ramWrEn = bus.memReady;
               end
               if (is_jump)
                  bus.pcSLoad = jmp_always | (jmp_on_mi & bus.mi) | (jmp_on_eq & bus.eq);
               if (is_imm) begin
                  bus.accLoad = 1'b1;
                  bus.aluOp   = dec_alu;
               end
            end
            S_EXEC2: begin
               bus.addrSel = 1'b0;
               bus.accLoad = bus.memReady;
               bus.aluOp   = dec_alu;
            end
            default: ;
         endcase
      end
   end

   assign bus.fetch   = fetch_q;
   assign bus.exec1   = exec1_q;
   assign bus.exec2   = exec2_q;
   assign bus.halted  = halted_q;
   assign bus.illegal = illegal_q;
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// tb_mu0_sequencer: directed + randomized bench for mu0_sequencer.
// The driver applies one input vector per cycle, predicts the cycle's outputs
// from an instruction-level model and queues the prediction; a monitor on the
// falling edge pops and compares. A second instance with CNTW=2 checks
// counter saturation.
module tb_mu0_sequencer;
   import mu0_pkg::*;

   localparam bit EXT =
`ifdef MU0_EXT_OPS_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic reset2;
   always #5 clk = ~clk;

   mu0_sequencer_if #(.OPW(4), .CNTW(16)) bus ();
   mu0_sequencer_if #(.OPW(4), .CNTW(2))  bus2 ();

   mu0_sequencer #(.OPW(4), .CNTW(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   mu0_sequencer #(.OPW(4), .CNTW(2)) dut2 (
      .clk   (clk),
      .reset (reset2),
      .bus   (bus2)
   );

   typedef struct packed {
      logic [3:0]  onehot;  // {halted, exec2, exec1, fetch}
      logic [5:0]  ctl;     // {irLoad, ramWrEn, accLoad, pcEnable, pcSLoad, addrSel}
      logic [2:0]  alu;
      logic        ill;
      logic [15:0] ret;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // instruction-level model: phase 0 fetch, 1 first exec, 2 second exec, 3 halted
   int          phase = 0;
   int unsigned m_ret = 0;
   bit          m_ill = 1'b0;
   logic [3:0]  cur_op = 4'd0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
      end
   endtask

   function automatic void retire_one();
      if (m_ret < 32'd65535) m_ret++;
   endfunction

   task automatic cyc(input logic [3:0] op, input bit e, input bit m,
                      input bit mr, input bit res, input bit rst);
      exp_t x;
      bit   irl, wr, al, pe, ps, as, legal;
      int   alu;
      @(posedge clk);
      #1;
      bus.opcode   = op;
      bus.eq       = e;
      bus.mi       = m;
      bus.memReady = mr;
      bus.resume   = res;
      reset        = rst;

      irl = 0; wr = 0; al = 0; pe = 0; ps = 0; as = 1; alu = 0;
      if (!rst) begin
         case (phase)
            0: begin irl = mr; pe = mr; end
            1: begin
               if (op == 0 || op == 2 || op == 3) as = 0;
               if (op == 1) begin as = 0; wr = mr; end
               if (op == 4) ps = 1;
               if (op == 5) ps = m;
               if (op == 6) ps = e;
               if (EXT && op >= 8 && op <= 10) begin al = 1; alu = int'(op) - 5; end
            end
            2: begin as = 0; al = mr; alu = (op == 0) ? 0 : int'(op) - 1; end
            default: ;
         endcase
      end
      x.onehot = 4'(1 << phase);
      x.ctl    = {irl, wr, al, pe, ps, as};
      x.alu    = 3'(alu);
      x.ill    = m_ill;
      x.ret    = 16'(m_ret);
      exp_q.push_back(x);

      legal = (op <= 7) || (EXT && op <= 10);
      if (rst) begin
         phase = 0; m_ret = 0; m_ill = 0;
      end else begin
         case (phase)
            0: if (mr) phase = 1;
            1: begin
               if (!legal) begin m_ill = 1; phase = 3; end
               else if (op == 7) begin retire_one(); phase = 3; end
               else if (op == 0 || op == 2 || op == 3) begin if (mr) phase = 2; end
               else if (op == 1) begin if (mr) begin retire_one(); phase = 0; end end
               else begin retire_one(); phase = 0; end
            end
            2: if (mr) begin retire_one(); phase = 0; end
            default: if (res) phase = 0;
         endcase
      end
   endtask

   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("state", {bus.halted, bus.exec2, bus.exec1, bus.fetch}, x.onehot);
            chk("ctl", {bus.irLoad, bus.ramWrEn, bus.accLoad, bus.pcEnable, bus.pcSLoad, bus.addrSel}, x.ctl);
            chk("aluOp", bus.aluOp, x.alu);
            chk("illegal", bus.illegal, x.ill);
            chk("retired", bus.retired, x.ret);
            chk("pc_exclusive", bus.pcEnable & bus.pcSLoad, 0);
            chk("wr_acc_exclusive", bus.ramWrEn & bus.accLoad, 0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit rst;
      reset         = 1'b1;
      bus.opcode    = '0;
      bus.eq        = 1'b0;
      bus.mi        = 1'b0;
      bus.memReady  = 1'b0;
      bus.resume    = 1'b0;
      reset2        = 1'b1;
      bus2.opcode   = OP_JMP;
      bus2.eq       = 1'b0;
      bus2.mi       = 1'b0;
      bus2.memReady = 1'b1;
      bus2.resume   = 1'b0;
      @(posedge clk);

      // LDA, no stalls
      repeat (3) cyc(OP_LDA, 0, 0, 1, 0, 0);
      // STA stalled two cycles in EXEC1
      cyc(OP_STA, 0, 0, 1, 0, 0);
      repeat (2) cyc(OP_STA, 0, 0, 0, 0, 0);
      cyc(OP_STA, 0, 0, 1, 0, 0);
      // JEQ not taken, then taken
      repeat (2) cyc(OP_JEQ, 0, 0, 1, 0, 0);
      repeat (2) cyc(OP_JEQ, 1, 0, 1, 0, 0);
      // JMI with mi set, then ADD/SUB
      repeat (2) cyc(OP_JMI, 0, 1, 1, 0, 0);
      repeat (3) cyc(OP_ADD, 0, 0, 1, 0, 0);
      repeat (3) cyc(OP_SUB, 0, 0, 1, 0, 0);
      // STP, idle in HALT, then resume
      repeat (2) cyc(OP_STP, 0, 0, 1, 0, 0);
      repeat (5) cyc(OP_STP, 0, 0, 1, 0, 0);
      cyc(OP_STP, 0, 0, 1, 1, 0);
      cyc(OP_LDI, 0, 0, 1, 0, 0);
      // opcode 12 then opcode 9, each cleared by reset
      repeat (2) cyc(4'd12, 0, 0, 1, 0, 0);
      cyc(4'd12, 0, 0, 1, 1, 0);
      cyc(4'd12, 0, 0, 1, 0, 1);
      repeat (2) cyc(OP_LSL, 0, 0, 1, 0, 0);
      repeat (2) cyc(OP_LSL, 0, 0, 1, 0, 0);
      cyc(OP_LSL, 0, 0, 0, 1, 1);

      for (int i = 0; i < 3000; i++) begin
         if (phase == 0)
            cur_op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 10))
                                                 : 4'($urandom_range(11, 15));
         rst = ($urandom_range(0, 49) == 0);
         cyc(cur_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), rst);
      end
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);

      // CNTW=2 instance: five back-to-back JMPs, counter must stop at 3
      @(posedge clk);
      #1 reset2 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         repeat (2) @(posedge clk);
         @(negedge clk);
         chk("sat_retired", bus2.retired, (k > 3) ? 3 : k);
         chk("sat_fetch", bus2.fetch, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mu0_sequencer.md
MU0_SEQUENCER -- requirements
Module: mu0_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-002 The block SHALL have parameter OPW, default 4: opcode width, minimum 4.
REQ-003 The block SHALL have parameter CNTW, default 16: width of the retired-instruction counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 opcode  input  OPW  instruction-register opcode field, valid from EXEC1 onward.
REQ-007 eq, mi  input  1 each  accumulator zero / negative flags.
REQ-008 memReady  input  1  memory handshake; low stalls any memory-access state.
REQ-009 resume  input  1  single-cycle pulse that leaves HALT.
REQ-010 irLoad, ramWrEn, accLoad, pcEnable, pcSLoad  output  1 each  IR load, RAM write, accumulator load, PC increment, PC jump-load.
REQ-011 addrSel  output  1  RAM address source: 1 = PC, 0 = IR address field.
REQ-012 aluOp  output  3  mu0_pkg ALU operation code.
REQ-013 fetch, exec1, exec2, halted  output  1 each  one-hot state indication.
REQ-014 illegal  output  1  sticky illegal-opcode flag.
REQ-015 retired  output  CNTW  count of completed instructions.

Function
REQ-016 The block SHALL have states FETCH, EXEC1, EXEC2 and HALT, with exactly one state active.
REQ-017 In FETCH: addrSel=1; irLoad=pcEnable=memReady; on memReady go to EXEC1, else hold.
REQ-018 Opcodes 0..10 SHALL be LDA, STA, ADD, SUB, JMP, JMI, JEQ, STP, LDI, LSL, LSR; every other value SHALL be illegal.
REQ-019 EXEC1 for LDA/ADD/SUB: addrSel=0; go to EXEC2 on memReady, else hold.
REQ-020 EXEC1 for STA: addrSel=0; ramWrEn=memReady; go to FETCH on memReady, else hold.
REQ-021 EXEC1 for JMP: pcSLoad=1.
REQ-022 EXEC1 for JMI: pcSLoad=mi.
REQ-023 EXEC1 for JEQ: pcSLoad=eq.
REQ-024 EXEC1 for a jump: go to FETCH in one cycle regardless of memReady; eq/mi are sampled only in this cycle.
REQ-025 EXEC1 for LDI/LSL/LSR: accLoad=1 with aluOp PASS_IMM/LSL/LSR; go to FETCH in one cycle.
REQ-026 EXEC2: addrSel=0; accLoad=memReady with aluOp PASS_MEM/ADD/SUB for LDA/ADD/SUB; go to FETCH on memReady, else hold.
REQ-027 EXEC1 with STP: go to HALT; no enable asserted.
REQ-028 EXEC1 with an illegal opcode: set illegal; go to HALT.
REQ-029 HALT: all enables low, addrSel=1; resume=1 goes to FETCH next cycle; PC is left untouched.
REQ-030 resume SHALL be ignored outside HALT.
REQ-031 pcEnable and pcSLoad SHALL never be high in the same cycle.
REQ-032 ramWrEn and accLoad SHALL never be high in the same cycle.
REQ-033 retired SHALL increment by 1 on each completing transition (EXEC1->FETCH, EXEC2->FETCH, STP EXEC1->HALT).
REQ-034 An illegal opcode SHALL not increment retired.
REQ-035 retired SHALL saturate at 2^CNTW-1 and not wrap.
REQ-036 illegal SHALL stay set until reset; resume does not clear it.

Reset
REQ-037 On reset=1 at a clock edge, regardless of state or stall: state=FETCH, retired=0, illegal=0.
REQ-038 While reset is high all enables SHALL be low and addrSel=1.
REQ-039 Reset SHALL take priority over resume and memReady.

Configuration
REQ-040 With macro MU0_EXT_OPS_EN defined, LDI, LSL and LSR SHALL execute per REQ-025.
REQ-041 Without MU0_EXT_OPS_EN, opcodes 8..10 SHALL be illegal per REQ-028, and aluOp SHALL never carry PASS_IMM, LSL or LSR.

Structure
REQ-042 Package mu0_pkg SHALL hold opcode constants, the state enum and the aluOp enum (PASS_MEM=0, ADD=1, SUB=2, PASS_IMM=3, LSL=4, LSR=5).
REQ-043 Opcode classification (extra-cycle, jump, write, immediate, illegal) SHALL live in combinational sub-module mu0_opdecode, instantiated once.

Verification
REQ-044 Reset, then LDA with memReady=1: fetch, exec1, exec2 over 3 cycles; accLoad=1, aluOp=0 in exec2; retired=1.
REQ-045 STA with memReady low 2 cycles in EXEC1: state holds, ramWrEn=0; ramWrEn=1 for exactly one cycle once memReady rises.
REQ-046 JEQ with eq=0, then JEQ with eq=1: pcSLoad 0 then 1; pcEnable=0 in both EXEC1 cycles; retired +2.
REQ-047 STP: halted=1, retired +1; resume held 0 for 5 cycles: no change; resume=1: fetch=1 next cycle.
REQ-048 Opcode 12, and opcode 9 without MU0_EXT_OPS_EN: illegal=1, halted=1, retired unchanged; reset clears both.
REQ-049 CNTW=2, run 5 single-cycle JMPs: retired reaches 3 and stays 3.
